// File: rtl/pipelined_cache_control.sv
// -----------------------------------------------------------------------------
// pipelined_cache_control
//
// Miss-handling controller for a 2-way, 8-set, 256-bit-line cache sitting in
// the second stage of a two-stage CPU access pipeline. Hits complete in the
// same cycle they are presented; misses stall the pipeline, optionally write
// back the dirty victim, fetch the new line, spend one cycle letting the
// arrays be re-read, and then let the held request complete as a hit.
//
// State | meaning
// ------+--------------------------------------------------------------------
// IDLE  | serving hits, or no request; pipeline advancing
// WB    | writing the dirty victim line back to physical memory
// FETCH | reading the missing line from physical memory into way lru
// REFILL| one stall cycle so stage 2 re-reads the freshly written arrays
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mem_read, mem_write stage-2 CPU request
//   hit, hit1           stage-2 registered hit and hit way
//   dirty, lru          victim (lru way) dirty bit and victim way
//   pmem_resp           physical memory transfer complete
//   pmem_read/_write    physical memory line requests
//   addr_sel            0 = CPU address, 1 = victim tag/set address
//   way_sel             way targeted by array writes
//   load_data, load_tag data / tag+valid array write enables
//   set_dirty, clear_dirty dirty bit update for way_sel
//   load_lru            point LRU at the way not just accessed
//   pipe_load           stage-1/stage-2 pipeline register enable
//   mem_resp            CPU request complete
//   miss_count          saturating miss counter since reset
// -----------------------------------------------------------------------------
module pipelined_cache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        hit,
    input  logic        hit1,
    input  logic        dirty,
    input  logic        lru,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic        addr_sel,
    output logic        way_sel,
    output logic        load_data,
    output logic        load_tag,
    output logic        set_dirty,
    output logic        clear_dirty,
    output logic        load_lru,
    output logic        pipe_load,
    output logic        mem_resp,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic        req;

    assign req        = mem_read | mem_write;
    assign miss_count = miss_count_q;

    always_comb begin
        state_d      = state_q;
        miss_count_d = miss_count_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        addr_sel     = 1'b0;
        way_sel      = 1'b0;
        load_data    = 1'b0;
        load_tag     = 1'b0;
        set_dirty    = 1'b0;
        clear_dirty  = 1'b0;
        load_lru     = 1'b0;
        pipe_load    = 1'b0;
        mem_resp     = 1'b0;

        if (rst) begin
            // Outputs look like an idle cycle with no request while in reset,
            // so an in-flight memory request is dropped immediately.
            pipe_load    = 1'b1;
            state_d      = S_IDLE;
            miss_count_d = 16'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!req) begin
                        pipe_load = 1'b1;
                    end else if (hit) begin
                        mem_resp  = 1'b1;
                        pipe_load = 1'b1;
                        load_lru  = 1'b1;
                        way_sel   = hit1;
                        if (mem_write) begin
                            load_data = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else begin
                        state_d = dirty ? S_WRITEBACK : S_FETCH;
                        if (miss_count_q != 16'hFFFF) begin
                            miss_count_d = miss_count_q + 16'd1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                    way_sel    = lru;
                    if (pmem_resp) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    pmem_read = 1'b1;
                    way_sel   = lru;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        load_tag    = 1'b1;
                        clear_dirty = 1'b1;
                        state_d     = S_REFILL;
                    end
                end
                S_REFILL: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        miss_count_q <= miss_count_d;
    end

endmodule

// File: tb/tb_pipelined_cache_control.sv
module tb_pipelined_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, hit, hit1, dirty, lru, pmem_resp;
    logic        pmem_read, pmem_write, addr_sel, way_sel, load_data, load_tag;
    logic        set_dirty, clear_dirty, load_lru, pipe_load, mem_resp;
    logic [15:0] miss_count;

    pipelined_cache_control dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .hit         (hit),
        .hit1        (hit1),
        .dirty       (dirty),
        .lru         (lru),
        .pmem_resp   (pmem_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .addr_sel    (addr_sel),
        .way_sel     (way_sel),
        .load_data   (load_data),
        .load_tag    (load_tag),
        .set_dirty   (set_dirty),
        .clear_dirty (clear_dirty),
        .load_lru    (load_lru),
        .pipe_load   (pipe_load),
        .mem_resp    (mem_resp),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One expected CPU transaction, derived from the request alone.
    typedef struct {
        bit we;
        bit miss;
        bit dirty;
        bit lru;
        bit way;
        int wb_cycles;
        int fe_cycles;
        int latency;
        int issue;
        int mcount;
    } exp_t;

    exp_t sbq[$];
    int   model_mc = 0;
    bit   mon_en   = 1'b0;

    // Monitor: per-cycle observations accumulated per transaction, compared
    // against the front of the scoreboard when the DUT reports completion.
    int wb_seen = 0, fe_seen = 0, tag_seen = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (pmem_read || pmem_write)
                chk("pmem_exclusive", int'(pmem_read & pmem_write), 0);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq[0];
                if (pmem_write) begin
                    wb_seen++;
                    chk("wb_addr_sel", int'(addr_sel), 1);
                    chk("wb_way_sel", int'(way_sel), int'(e.lru));
                    chk("wb_pipe_load", int'(pipe_load), 0);
                end
                if (pmem_read) begin
                    fe_seen++;
                    chk("fetch_addr_sel", int'(addr_sel), 0);
                    chk("fetch_way_sel", int'(way_sel), int'(e.lru));
                    chk("fetch_pipe_load", int'(pipe_load), 0);
                end
                if (load_tag) begin
                    tag_seen++;
                    chk("fill_on_resp", int'(pmem_resp & pmem_read), 1);
                    chk("fill_load_data", int'(load_data), 1);
                    chk("fill_clear_dirty", int'(clear_dirty), 1);
                end
                if (mem_resp) begin
                    void'(sbq.pop_front());
                    chk("latency", cyc - e.issue, e.latency);
                    chk("resp_way_sel", int'(way_sel), int'(e.way));
                    chk("resp_load_data", int'(load_data), int'(e.we));
                    chk("resp_set_dirty", int'(set_dirty), int'(e.we));
                    chk("resp_load_lru", int'(load_lru), 1);
                    chk("resp_pipe_load", int'(pipe_load), 1);
                    chk("resp_no_pmem", int'(pmem_read | pmem_write), 0);
                    chk("miss_count", int'(miss_count), e.mcount);
                    chk("wb_cycles", wb_seen, (e.miss && e.dirty) ? e.wb_cycles : 0);
                    chk("fetch_cycles", fe_seen, e.miss ? e.fe_cycles : 0);
                    chk("load_tag_pulses", tag_seen, e.miss ? 1 : 0);
                    wb_seen  = 0;
                    fe_seen  = 0;
                    tag_seen = 0;
                end
            end else begin
                chk("idle_pipe_load", int'(pipe_load), 1);
                chk("idle_no_pmem", int'(pmem_read | pmem_write), 0);
                chk("idle_no_resp", int'(mem_resp), 0);
            end
        end
    end

    // Driver acting as CPU, tag/data arrays and physical memory for one request.
    task automatic do_txn(input bit we, input bit is_hit, input bit h1, input bit dty,
                          input bit vlru, input int wlat, input int flat, input bit drop);
        exp_t e;
        int   cnt     = 0;
        bit   fetched = 1'b0;
        bit   done    = 1'b0;
        e.we        = we;
        e.miss      = !is_hit;
        e.dirty     = dty;
        e.lru       = vlru;
        e.way       = is_hit ? h1 : vlru;
        e.wb_cycles = wlat;
        e.fe_cycles = flat;
        e.latency   = is_hit ? 0 : ((dty ? wlat : 0) + flat + 2);
        if (!is_hit && model_mc != 65535) model_mc++;
        e.mcount    = model_mc;
        @(posedge clk); #1;
        e.issue = cyc;
        sbq.push_back(e);
        mem_read  = !we;
        mem_write = we;
        hit       = is_hit;
        hit1      = h1;
        dirty     = dty;
        lru       = vlru;
        pmem_resp = 1'b0;
        #1;
        if (mem_resp) done = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (fetched) begin
                hit       = 1'b1;
                hit1      = vlru;
                mem_read  = !we;
                mem_write = we;
            end
            if (pmem_read || pmem_write) begin
                if (drop && !fetched) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
                cnt++;
                if (cnt >= (pmem_write ? wlat : flat)) begin
                    if (pmem_read) fetched = 1'b1;
                    pmem_resp = 1'b1;
                    cnt       = 0;
                end
            end
            #1;
            if (mem_resp) done = 1'b1;
        end
        if (!done) chk("txn_timeout", 0, 1);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int fetches;
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1; hit1 = 1'b1;
        dirty = 1'b0; lru = 1'b0; pmem_resp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_resp", int'(mem_resp), 0);
        chk("reset_pipe_load", int'(pipe_load), 1);
        chk("reset_load_lru", int'(load_lru), 0);
        chk("reset_pmem", int'(pmem_read | pmem_write), 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        chk("reset_miss_count", int'(miss_count), 0);
        mon_en = 1'b1;

        do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0); // read hit way 1
        do_txn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0); // write hit way 0
        do_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0); // clean read miss
        do_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 1'b0); // dirty miss, victim way 1
        do_txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3, 1'b1); // dirty write miss, request dropped

        for (int i = 0; i < 300; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(1, 5),
                   $urandom_range(1, 5), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        // Reset during the second FETCH cycle.
        mon_en = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_fetch", int'(pmem_read), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
        @(negedge clk);
        chk("post_reset_pmem_read", int'(pmem_read), 0);
        chk("post_reset_miss_count", int'(miss_count), 0);
        chk("post_reset_pipe_load", int'(pipe_load), 1);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("stale_resp_ignored", int'(pmem_read | pmem_write | load_tag), 0);
        chk("stale_resp_pipe_load", int'(pipe_load), 1);
        model_mc = 0;
        mon_en   = 1'b1;
        do_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0); // first miss after reset
        idle_cycle();

        // Saturation: keep missing with single-cycle fetches.
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        fetches = 0;
        for (int n = 0; n < 210000 && fetches < 65540; n++) begin
            @(posedge clk); #1;
            pmem_resp = pmem_read;
            if (pmem_read) begin
                fetches++;
                if (fetches == 100)   chk("miss_count_100", int'(miss_count), 100);
                if (fetches == 65535) chk("miss_count_65535", int'(miss_count), 65535);
            end
        end
        chk("saturation_reached", fetches, 65540);
        @(posedge clk); #1;
        mem_read = 1'b0; pmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("miss_count_saturated", int'(miss_count), 65535);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cache_control.md
PIPELINED_CACHE_CONTROL -- requirements
Module: pipelined_cache_control

Interface
REQ-001: Parameters: none; geometry is fixed at 2 ways, 8 sets, 256-bit lines.
REQ-002: clk  in  1  clock; all state updates on posedge.
REQ-003: rst  in  1  reset, synchronous, active-high.
REQ-004: mem_read  in  1  stage-2 CPU read request.
REQ-005: mem_write  in  1  stage-2 CPU write request.
REQ-006: hit  in  1  stage-2 registered hit.
REQ-007: hit1  in  1  hit occurred in way 1.
REQ-008: dirty  in  1  stage-2 victim (lru way) dirty bit.
REQ-009: lru  in  1  stage-2 LRU way (victim way).
REQ-010: pmem_resp  in  1  physical memory transfer complete.
REQ-011: pmem_read  out  1  physical memory line read request.
REQ-012: pmem_write  out  1  physical memory line write request.
REQ-013: addr_sel  out  1  0 = CPU address, 1 = victim tag/set address.
REQ-014: way_sel  out  1  way targeted by array writes.
REQ-015: load_data  out  1  write data array (way way_sel).
REQ-016: load_tag  out  1  write tag array and set valid.
REQ-017: set_dirty  out  1  set dirty bit of way_sel.
REQ-018: clear_dirty  out  1  clear dirty bit of way_sel.
REQ-019: load_lru  out  1  update LRU to the way not just accessed.
REQ-020: pipe_load  out  1  load enable for the stage-1/stage-2 pipeline registers.
REQ-021: mem_resp  out  1  CPU request complete.
REQ-022: miss_count  out  16  saturating count of misses since reset.

Function
REQ-023: Request = mem_read OR mem_write; the FSM has four states: IDLE, WRITEBACK, FETCH, REFILL.
REQ-024: All outputs except miss_count are decoded from state and inputs combinationally; the default for every output is 0.
REQ-025: IDLE, no request: pipe_load=1, all other control outputs 0.
REQ-026: IDLE, request and hit: mem_resp=1, pipe_load=1, load_lru=1 in the same cycle (zero added latency); way_sel=hit1.
REQ-027: IDLE, write hit: additionally load_data=1 and set_dirty=1 for way hit1.
REQ-028: IDLE, request, miss, dirty: pipe_load=0; next state WRITEBACK; miss_count increments.
REQ-029: IDLE, request, miss, clean: pipe_load=0; next state FETCH; miss_count increments.
REQ-030: WRITEBACK: pmem_write=1, addr_sel=1, way_sel=lru, pipe_load=0; holds until pmem_resp=1, then moves to FETCH.
REQ-031: FETCH: pmem_read=1, addr_sel=0, way_sel=lru, pipe_load=0; on pmem_resp=1 assert load_data, load_tag and clear_dirty in that cycle, then move to REFILL.
REQ-032: REFILL: a single cycle with pipe_load=0 and no memory request, allowing the arrays to be re-read; then move to IDLE, where the held request now hits.
REQ-033: pmem_read and pmem_write are never asserted together, and each is deasserted in the cycle after pmem_resp.
REQ-034: pmem_resp in IDLE or REFILL is ignored and causes no state change.
REQ-035: A request that is deasserted while in WRITEBACK/FETCH does not abort the transfer; the FSM completes to IDLE.
REQ-036: miss_count saturates at 16'hFFFF and does not wrap.
REQ-037: Clean-miss latency: miss cycle t, FETCH from t+1, pmem_resp at cycle k, REFILL at k+1, mem_resp at k+2.

Reset
REQ-038: rst=1 forces state to IDLE and miss_count to 0 at the next posedge, regardless of the current state.
REQ-039: Reset in WRITEBACK/FETCH drops pmem_write/pmem_read in the cycle after the reset edge; a pending pmem_resp is ignored.
REQ-040: Outputs during reset decode as IDLE with no request.

Verification
REQ-041: Read hit (mem_read=1, hit=1, hit1=1) -> same cycle mem_resp=1, load_lru=1, way_sel=1, pmem_read=0.
REQ-042: Write hit (mem_write=1, hit=1, hit1=0) -> load_data=1, set_dirty=1, way_sel=0, mem_resp=1.
REQ-043: Clean read miss (lru=0, dirty=0), pmem_resp 5 cycles after FETCH entry -> pmem_read high 5 cycles, load_tag pulse 1 cycle, REFILL 1 cycle, then mem_resp when hit=1; miss_count=1.
REQ-044: Dirty miss (lru=1, dirty=1) -> WRITEBACK with pmem_write=1, addr_sel=1, way_sel=1 until pmem_resp; then FETCH with pmem_read=1; the two requests never overlap.
REQ-045: rst asserted in the 2nd cycle of FETCH -> IDLE next edge, pmem_read=0, miss_count=0; a subsequent pmem_resp causes no change.
REQ-046: 65540 forced misses -> miss_count holds at 16'hFFFF.
